// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package : mem_arb_pkg
// Brief   : Shared types and requester ids for the memory arbiter.
// Rev     : 1.0  initial release
// ============================================================================
package mem_arb_pkg;

    // Sequencer states for one memory access
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    // Requester identifiers used for grant id and last-grant pointer
    localparam logic REQ_FETCH = 1'b0;
    localparam logic REQ_DATA  = 1'b1;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_arbiter_arb2_pick.sv
`default_nettype none
// ============================================================================
// Module  : arb2_pick
// Brief   : Combinational two-way picker. With MEM_ARB_RR_EN defined a tie is
//           broken in favour of the requester not granted last; otherwise
//           data always beats fetch.
// Rev     : 1.0  initial release
// ============================================================================
module arb2_pick
    import mem_arb_pkg::*;
(
    input  logic elig_f,
    input  logic elig_d,
    input  logic last,
    output logic valid,
    output logic id
);

`ifndef MEM_ARB_RR_EN
    // Fixed priority ignores the pointer
    logic unused_last;
    assign unused_last = last;
`endif

    // Pick a winner among the eligible requesters
    always_comb begin
        valid = elig_f | elig_d;
`ifdef MEM_ARB_RR_EN
        if (elig_f && elig_d)
            id = (last == REQ_FETCH) ? REQ_DATA : REQ_FETCH;
        else
            id = elig_d ? REQ_DATA : REQ_FETCH;
`else
        id = elig_d ? REQ_DATA : REQ_FETCH;
`endif
    end

endmodule : arb2_pick
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_arbiter
// Brief   : Shares a single-port synchronous memory between instruction fetch
//           (read-only) and load/store (read/write). One access per two
//           cycles; ack with read data in the cycle after the memory samples.
//           Optional round-robin arbitration via MEM_ARB_RR_EN.
// Rev     : 1.0  initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int W = 32,
    parameter int D = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_f_req,
    input  logic [D-1:0] i_f_addr,
    output logic         o_f_ack,
    input  logic         i_d_req,
    input  logic         i_d_we,
    input  logic [D-1:0] i_d_addr,
    input  logic [W-1:0] i_d_wdata,
    output logic         o_d_ack,
    output logic [W-1:0] o_rdata,
    output logic [D-1:0] o_mem_addr,
    output logic [W-1:0] o_mem_data,
    output logic         o_mem_we,
    input  logic [W-1:0] i_mem_data
);

    state_t state;
    state_t state_nxt;
    logic   grant_id;
    logic   is_read;
    logic   last_grant;
    logic   elig_f;
    logic   elig_d;
    logic   pick_valid;
    logic   pick_id;

    // Eligibility: the requester being acked still holds req for the finished
    // transfer, so it must be masked in RESP to avoid a double service
    always_comb begin
        elig_f = 1'b0;
        elig_d = 1'b0;
        case (state)
            IDLE: begin
                elig_f = i_f_req;
                elig_d = i_d_req;
            end
            RESP: begin
                elig_f = i_f_req && (grant_id != REQ_FETCH);
                elig_d = i_d_req && (grant_id != REQ_DATA);
            end
            default: begin
                elig_f = 1'b0;
                elig_d = 1'b0;
            end
        endcase
    end

    arb2_pick u_pick (
        .elig_f (elig_f),
        .elig_d (elig_d),
        .last   (last_grant),
        .valid  (pick_valid),
        .id     (pick_id)
    );

    // Next-state logic; a grant (IDLE or RESP only) always leads to ISSUE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = pick_valid ? ISSUE : IDLE;
            ISSUE:   state_nxt = RESP;
            RESP:    state_nxt = pick_valid ? ISSUE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

`ifdef MEM_ARB_RR_EN
    // Last-grant pointer; starts at DATA so fetch wins the first tie
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            last_grant <= REQ_DATA;
        else if (pick_valid)
            last_grant <= pick_id;
    end
`else
    assign last_grant = REQ_DATA;
`endif

    // Register the winner onto the memory port; write enable lasts one cycle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            grant_id   <= REQ_FETCH;
            is_read    <= 1'b0;
            o_mem_addr <= '0;
            o_mem_data <= '0;
            o_mem_we   <= 1'b0;
        end else if (pick_valid) begin
            grant_id <= pick_id;
            if (pick_id == REQ_DATA) begin
                o_mem_addr <= i_d_addr;
                o_mem_data <= i_d_wdata;
                o_mem_we   <= i_d_we;
                is_read    <= !i_d_we;
            end else begin
                o_mem_addr <= i_f_addr;
                o_mem_we   <= 1'b0;
                is_read    <= 1'b1;
            end
        end else begin
            o_mem_we <= 1'b0;
        end
    end

    // Acks and read data are valid only in RESP; write acks return zero
    always_comb begin
        o_f_ack = (state == RESP) && (grant_id == REQ_FETCH);
        o_d_ack = (state == RESP) && (grant_id == REQ_DATA);
        o_rdata = ((state == RESP) && is_read) ? i_mem_data : '0;
    end

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_arbiter
// Brief   : Self-checking bench for mem_arbiter with a transaction-level
//           reference model (grant points, shadow memory, expected acks).
// Rev     : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int W = 32;
    localparam int D = 8;

    typedef struct {
        bit           we;
        logic [D-1:0] a;
        logic [W-1:0] d;
    } dreq_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         f_req, d_req, d_we;
    logic [D-1:0] f_addr, d_addr;
    logic [W-1:0] d_wdata;
    logic         f_ack, d_ack;
    logic [W-1:0] rdata;
    logic [D-1:0] mem_addr;
    logic [W-1:0] mem_wdata;
    logic         mem_we;
    logic [W-1:0] mem_q;

    logic         ld_en;
    logic [D-1:0] ld_addr;
    logic [W-1:0] ld_data;
    logic [W-1:0] mem [0:255];

    int checks = 0;
    int errors = 0;
    int cyc;

    // Reference model state
    logic [W-1:0] ref_mem [0:255];
    int           free_at, ack_at, iss_at;
    bit           ack_id, iss_we, last_g;
    logic [W-1:0] ack_rdata, iss_data;
    logic [D-1:0] iss_addr;

    // Requester drivers
    logic [D-1:0] fq[$];
    dreq_t        dq[$];
    bit           f_act, f_done, d_act, d_done, gaps;
    int           f_ack_cyc, d_ack_cyc, f_ack_cnt;
    logic [W-1:0] f_ack_data, d_ack_data;

    always #5 clk = ~clk;

    mem_arbiter #(.W(W), .D(D)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_f_req    (f_req),
        .i_f_addr   (f_addr),
        .o_f_ack    (f_ack),
        .i_d_req    (d_req),
        .i_d_we     (d_we),
        .i_d_addr   (d_addr),
        .i_d_wdata  (d_wdata),
        .o_d_ack    (d_ack),
        .o_rdata    (rdata),
        .o_mem_addr (mem_addr),
        .o_mem_data (mem_wdata),
        .o_mem_we   (mem_we),
        .i_mem_data (mem_q)
    );

    // Single-port memory: write or read per cycle, registered read data
    always @(posedge clk) begin
        if (ld_en)
            mem[ld_addr] <= ld_data;
        else if (mem_we)
            mem[mem_addr] <= mem_wdata;
        else
            mem_q <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        free_at = cyc;
        ack_at  = -1;
        iss_at  = -1;
        last_g  = 1'b1;
    endtask

    // Apply requester behaviour for the current cycle
    task automatic drive();
        if (f_done) begin
            void'(fq.pop_front());
            f_act = 0; f_done = 0; f_req = 1'b0;
        end
        if (d_done) begin
            void'(dq.pop_front());
            d_act = 0; d_done = 0; d_req = 1'b0;
        end
        if (!f_act && fq.size() > 0 && !(gaps && $urandom_range(2) == 0)) begin
            f_req = 1'b1; f_addr = fq[0]; f_act = 1;
        end
        if (!d_act && dq.size() > 0 && !(gaps && $urandom_range(2) == 0)) begin
            d_req = 1'b1; d_we = dq[0].we; d_addr = dq[0].a; d_wdata = dq[0].d; d_act = 1;
        end
    endtask

    // Compare this cycle's outputs with the model's expectations
    task automatic check();
        bit           ef, ed, ew;
        logic [W-1:0] er;
        ef = (ack_at == cyc) && !ack_id;
        ed = (ack_at == cyc) && ack_id;
        er = (ack_at == cyc) ? ack_rdata : '0;
        ew = (iss_at == cyc) && iss_we;
        chk("f_ack", f_ack, ef);
        chk("d_ack", d_ack, ed);
        chk("rdata", rdata, er);
        chk("mem_we", mem_we, ew);
        if (iss_at == cyc) chk("mem_addr", mem_addr, iss_addr);
        if (iss_at == cyc && iss_we) chk("mem_data", mem_wdata, iss_data);
        if (f_ack) begin f_ack_cyc = cyc; f_ack_data = rdata; f_ack_cnt++; end
        if (d_ack) begin d_ack_cyc = cyc; d_ack_data = rdata; end
        if (ef && f_act) f_done = 1;
        if (ed && d_act) d_done = 1;
    endtask

    // Grant points: one access occupies two cycles; the requester acked in a
    // cycle cannot be granted again in that same cycle
    task automatic model_grant();
        bit ef, ed, w;
        if (cyc >= free_at) begin
            ef = f_req && !((ack_at == cyc) && !ack_id);
            ed = d_req && !((ack_at == cyc) && ack_id);
            if (ef || ed) begin
`ifdef MEM_ARB_RR_EN
                w = (ef && ed) ? !last_g : ed;
`else
                w = ed;
`endif
                last_g  = w;
                ack_id  = w;
                iss_at  = cyc + 1;
                ack_at  = cyc + 2;
                free_at = cyc + 2;
                if (w) begin
                    iss_addr  = d_addr;
                    iss_we    = d_we;
                    iss_data  = d_wdata;
                    ack_rdata = d_we ? '0 : ref_mem[d_addr];
                    if (d_we) ref_mem[d_addr] = d_wdata;
                end else begin
                    iss_addr  = f_addr;
                    iss_we    = 1'b0;
                    ack_rdata = ref_mem[f_addr];
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        drive();
        #1;
        check();
        model_grant();
    endtask

    task automatic run(input string tag, input int limit);
        int n = 0;
        while ((fq.size() > 0 || dq.size() > 0) && n < limit) begin
            step();
            n++;
        end
        chk(tag, (n < limit), 1'b1);
        step();
    endtask

    initial begin
        int           t0;
        int           cnt0;
        logic [W-1:0] v;
        dreq_t        r;

        f_req = 0; d_req = 0; d_we = 0; f_addr = '0; d_addr = '0; d_wdata = '0;
        f_act = 0; f_done = 0; d_act = 0; d_done = 0; gaps = 0;
        f_ack_cnt = 0; f_ack_cyc = -1; d_ack_cyc = -1;
        rst_n = 1'b0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;

        // Preload memory while the arbiter is held in reset
        for (int i = 0; i < 256; i++) begin
            v = (i == 16) ? 32'hDEADBEEF : $urandom;
            ld_en = 1'b1; ld_addr = i[D-1:0]; ld_data = v;
            ref_mem[i] = v;
            @(posedge clk); #1;
        end
        ld_en = 1'b0;

        chk("rst_f_ack", f_ack, 1'b0);
        chk("rst_d_ack", d_ack, 1'b0);
        chk("rst_rdata", rdata, '0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, '0);
        chk("rst_mem_data", mem_wdata, '0);

        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc = 0;
        model_reset();

        // Single fetch of a preloaded word
        t0 = cyc + 1;
        fq.push_back(8'h10);
        run("single_fetch_drain", 50);
        chk("single_fetch_ack_cyc", f_ack_cyc, t0 + 2);
        chk("single_fetch_rdata", f_ack_data, 32'hDEADBEEF);

        // Write then read back the same address
        t0 = cyc + 1;
        r.we = 1; r.a = 8'h20; r.d = 32'h12345678;
        dq.push_back(r);
        run("write_drain", 50);
        chk("write_ack_cyc", d_ack_cyc, t0 + 2);
        chk("write_ack_rdata", d_ack_data, '0);
        r.we = 0; r.d = '0;
        dq.push_back(r);
        run("read_drain", 50);
        chk("readback_rdata", d_ack_data, 32'h12345678);

        // Simultaneous requests, twice
        t0 = cyc + 1;
        fq.push_back(8'h05);
        r.we = 0; r.a = 8'h06;
        dq.push_back(r);
        run("tie1_drain", 50);
`ifdef MEM_ARB_RR_EN
        chk("tie1_f_ack_cyc", f_ack_cyc, t0 + 2);
        chk("tie1_d_ack_cyc", d_ack_cyc, t0 + 4);
`else
        chk("tie1_d_ack_cyc", d_ack_cyc, t0 + 2);
        chk("tie1_f_ack_cyc", f_ack_cyc, t0 + 4);
`endif
        fq.push_back(8'h07);
        r.we = 1; r.a = 8'h08; r.d = 32'hA5A5_0001;
        dq.push_back(r);
        run("tie2_drain", 50);

        // Back-to-back fetches with req held high between accesses
        cnt0 = f_ack_cnt;
        for (int i = 0; i < 4; i++) fq.push_back(i[D-1:0]);
        run("b2b_drain", 100);
        chk("b2b_ack_count", f_ack_cnt - cnt0, 4);

        // Reset pulse while a fetch sits in ISSUE
        fq.push_back(8'h33);
        step();
        step();
        chk("pre_rst_in_issue", iss_at, cyc);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_f_ack", f_ack, 1'b0);
        chk("mid_rst_d_ack", d_ack, 1'b0);
        chk("mid_rst_rdata", rdata, '0);
        chk("mid_rst_mem_we", mem_we, 1'b0);
        chk("mid_rst_mem_addr", mem_addr, '0);
        chk("mid_rst_mem_data", mem_wdata, '0);
        @(posedge clk);
        cyc++;
        #1;
        rst_n = 1'b1;
        model_reset();
        t0 = cyc;
        #1;
        check();
        model_grant();
        run("post_rst_drain", 50);
        chk("post_rst_ack_cyc", f_ack_cyc, t0 + 2);
        chk("post_rst_rdata", f_ack_data, ref_mem[8'h33]);

        // Randomized mixed traffic with random gaps
        gaps = 1;
        for (int i = 0; i < 40; i++) begin
            fq.push_back(D'($urandom_range(255)));
            r.we = bit'($urandom_range(1));
            r.a  = D'($urandom_range(255));
            r.d  = $urandom;
            dq.push_back(r);
        end
        run("random_drain", 2000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mem_arbiter
`default_nettype wire
